parity_stream: RTL and testbench

PARITY_STREAM -- requirements
Module: parity_stream

---
 rtl/parity_pkg.sv | 26 ++
 rtl/parity_stream_if.sv | 53 +++++
 rtl/parity_calc.sv | 28 ++
 rtl/parity_stream.sv | 145 ++++++++++++++
 tb/tb_parity_stream.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// ============================================================================
// Module  : parity_pkg
// Purpose : Shared constants for the parity_stream block: parity mode
//           encodings, the frame bit index that carries parity, and the
//           depth of the generator frame FIFO.
// Ports   : none (package)
// Macros  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package parity_pkg;

  // Parity mode encodings used by parity_odd / chk_odd
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  // Frame layout: parity in bit 0, payload above it
  localparam int   PARITY_BIT = 0;

  // Generator frame FIFO depth
  localparam int   FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/parity_stream_if.sv
// ============================================================================
// Module  : parity_stream_if
// Purpose : Bundles the generator handshake, checker inputs and error
//           counter signals of parity_stream.
// Ports   : master - drives in_valid/in_data/parity_odd/out_ready,
//                    chk_valid/chk_frame/chk_odd, err_clr
//           slave  - drives in_ready, out_valid/out_frame, chk_err, err_cnt
// Macros  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface parity_stream_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
);

  // Generator input side
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 parity_odd;

  // Generator output side
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH:0]       out_frame;

  // Checker
  logic                 chk_valid;
  logic [WIDTH:0]       chk_frame;
  logic                 chk_odd;
  logic                 chk_err;

  // Error counter
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_data, parity_odd, out_ready,
    output chk_valid, chk_frame, chk_odd, err_clr,
    input  in_ready, out_valid, out_frame, chk_err, err_cnt
  );

  modport slave (
    input  in_valid, in_data, parity_odd, out_ready,
    input  chk_valid, chk_frame, chk_odd, err_clr,
    output in_ready, out_valid, out_frame, chk_err, err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/parity_calc.sv
// ============================================================================
// Module  : parity_calc
// Purpose : Combinational parity bit for a WIDTH-bit word. Even mode makes
//           the total ones-count of {data, parity} even, odd mode makes it
//           odd.
// Ports   : i_data   - payload word
//           i_odd    - 0 = even parity, 1 = odd parity
//           o_parity - parity bit to append
// Macros  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_calc
  import parity_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_odd,
  output logic                  o_parity
);

  assign o_parity = (i_odd == PAR_ODD) ? ~^i_data : ^i_data;

endmodule

`default_nettype wire

// File: rtl/parity_stream.sv
// ============================================================================
// Module  : parity_stream
// Purpose : Parity framing generator with a 2-entry output FIFO plus an
//           independent registered parity checker and optional saturating
//           error counter.
// Ports   : clk    - rising-edge clock
//           reset  - synchronous active-high reset
//           bus    - parity_stream_if.slave (generator in/out handshakes,
//                    checker frame input, chk_err, err_clr, err_cnt)
// Macros  : PARITY_ERR_CNT_EN - when defined, err_cnt counts detected
//           errors (saturating) and err_clr clears it; otherwise err_cnt
//           is tied to 0 and err_clr is ignored.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_stream
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  parity_stream_if.slave bus
);

  localparam int c_FRAME_W = WIDTH + 1;

  // --------------------------------------------------------------------------
  // Generator: parity bit for the incoming word, sampled with the push so a
  // later parity_odd change never touches frames already buffered.
  // --------------------------------------------------------------------------
  logic                 w_gen_par;
  logic [c_FRAME_W-1:0] w_gen_frame;

  parity_calc #(.WIDTH(WIDTH)) u_gen_calc (
    .i_data   (bus.in_data),
    .i_odd    (bus.parity_odd),
    .o_parity (w_gen_par)
  );

  assign w_gen_frame = {bus.in_data, w_gen_par};

  // --------------------------------------------------------------------------
  // 2-entry frame FIFO. in_ready depends only on occupancy, so there is no
  // combinational path from out_ready to in_ready; a full FIFO therefore
  // takes one cycle after a pop to accept again.
  // --------------------------------------------------------------------------
  logic [c_FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_count;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_push;
  logic                 w_pop;

  assign w_in_ready  = (r_count < 2'(FIFO_DEPTH));
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the output is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_gen_frame;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_frame = w_out_valid ? r_mem[r_rd_ptr] : '0;

  // --------------------------------------------------------------------------
  // Checker: recompute the parity of the received payload in the requested
  // mode and compare with the received parity bit; result is registered.
  // --------------------------------------------------------------------------
  logic w_chk_par;
  logic w_chk_err_det;
  logic r_chk_err;

  parity_calc #(.WIDTH(WIDTH)) u_chk_calc (
    .i_data   (bus.chk_frame[WIDTH:PARITY_BIT+1]),
    .i_odd    (bus.chk_odd),
    .o_parity (w_chk_par)
  );

  assign w_chk_err_det = bus.chk_valid & (w_chk_par != bus.chk_frame[PARITY_BIT]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_err <= 1'b0;
    end else begin
      r_chk_err <= w_chk_err_det;
    end
  end

  assign bus.chk_err = r_chk_err;

  // --------------------------------------------------------------------------
  // Error counter. It is updated on the same edge that raises chk_err, so
  // err_cnt already includes an error when its chk_err pulse is visible.
  // A clear coinciding with a detected error leaves a count of one.
  // --------------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= ERR_CNT_W'(w_chk_err_det);
    end else if (w_chk_err_det && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = bus.err_clr;
  assign bus.err_cnt      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_stream.sv
// ============================================================================
// Module  : tb_parity_stream
// Purpose : Directed self-checking bench for parity_stream (WIDTH=8,
//           ERR_CNT_W=4). Expected err_cnt values follow PARITY_ERR_CNT_EN.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parity_stream;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  parity_stream_if #(.WIDTH(8), .ERR_CNT_W(4)) u_if ();

  parity_stream #(.WIDTH(8), .ERR_CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value given the number of errors seen since last clear
  function automatic logic [3:0] exp_cnt(input int n);
`ifdef PARITY_ERR_CNT_EN
    return (n > 15) ? 4'hF : 4'(n);
`else
    return 4'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    u_if.in_valid   = 1'b0;
    u_if.in_data    = 8'h00;
    u_if.parity_odd = 1'b0;
    u_if.out_ready  = 1'b0;
    u_if.chk_valid  = 1'b0;
    u_if.chk_frame  = 9'h000;
    u_if.chk_odd    = 1'b0;
    u_if.err_clr    = 1'b0;
    tick();
    tick();
    checks += 5;
    if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", u_if.out_valid); end
    if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", u_if.in_ready); end
    if (u_if.out_frame !== 9'h000) begin failures++; $display("FAIL reset_out_frame got=%h exp=000", u_if.out_frame); end
    if (u_if.chk_err !== 1'b0) begin failures++; $display("FAIL reset_chk_err got=%b exp=0", u_if.chk_err); end
    if (u_if.err_cnt !== 4'h0) begin failures++; $display("FAIL reset_err_cnt got=%h exp=0", u_if.err_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frames();
    logic [7:0] data_v [3] = '{8'h00, 8'h01, 8'h00};
    logic       odd_v  [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] exp_v  [3] = '{9'h000, 9'h003, 9'h001};
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_if.in_data    = data_v[i];
      u_if.parity_odd = odd_v[i];
      tick();
      checks += 2;
      if (u_if.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, u_if.out_valid); end
      if (u_if.out_frame !== exp_v[i]) begin failures++; $display("FAIL basic_frame[%0d] got=%h exp=%h", i, u_if.out_frame, exp_v[i]); end
    end
    u_if.in_valid = 1'b0;
    tick();
    checks++;
    if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", u_if.out_valid); end
  endtask

  task automatic test_all_values();
    logic [7:0] d;
    logic [8:0] exp_f;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d               = 8'(i);
      u_if.in_data    = d;
      u_if.parity_odd = d[0];
      exp_f           = {d, (^d) ^ d[0]};
      tick();
      checks++;
      if (u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b1 || u_if.out_frame !== exp_f) begin
        failures++;
        $display("FAIL all_values[%0d] valid=%b ready=%b got=%h exp=%h", i, u_if.out_valid, u_if.in_ready, u_if.out_frame, exp_f);
      end
    end
    u_if.in_valid = 1'b0;
    tick();
    checks++;
    if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL all_values_drain got=%b exp=0", u_if.out_valid); end
  endtask

  task automatic test_backpressure();
    // A1 even -> 143, A2 odd -> 144, A3 even -> 146
    u_if.out_ready  = 1'b0;
    u_if.in_valid   = 1'b1;
    u_if.in_data    = 8'hA1;
    u_if.parity_odd = 1'b0;
    tick();
    checks += 2;
    if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", u_if.in_ready); end
    if (u_if.out_frame !== 9'h143) begin failures++; $display("FAIL bp_head1 got=%h exp=143", u_if.out_frame); end
    u_if.in_data    = 8'hA2;
    u_if.parity_odd = 1'b1;
    tick();
    checks++;
    if (u_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", u_if.in_ready); end
    u_if.in_data    = 8'hA3;
    u_if.parity_odd = 1'b0;
    tick();
    checks += 3;
    if (u_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", u_if.in_ready); end
    if (u_if.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", u_if.out_valid); end
    if (u_if.out_frame !== 9'h143) begin failures++; $display("FAIL bp_stable got=%h exp=143", u_if.out_frame); end
    u_if.out_ready = 1'b1;
    tick();
    checks += 2;
    if (u_if.out_frame !== 9'h144) begin failures++; $display("FAIL bp_head2 got=%h exp=144", u_if.out_frame); end
    if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", u_if.in_ready); end
    tick();
    checks++;
    if (u_if.out_frame !== 9'h146) begin failures++; $display("FAIL bp_head3 got=%h exp=146", u_if.out_frame); end
    u_if.in_valid = 1'b0;
    tick();
    checks++;
    if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", u_if.out_valid); end
  endtask

  task automatic test_checker();
    logic [8:0] frm_v [4] = '{9'h003, 9'h002, 9'h001, 9'h000};
    logic       odd_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       err_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         nerr;
    nerr = 0;
    for (int i = 0; i < 4; i++) begin
      u_if.chk_valid = 1'b1;
      u_if.chk_frame = frm_v[i];
      u_if.chk_odd   = odd_v[i];
      if (err_v[i]) nerr++;
      tick();
      checks += 2;
      if (u_if.chk_err !== err_v[i]) begin failures++; $display("FAIL chk_err[%0d] got=%b exp=%b", i, u_if.chk_err, err_v[i]); end
      if (u_if.err_cnt !== exp_cnt(nerr)) begin failures++; $display("FAIL chk_cnt[%0d] got=%h exp=%h", i, u_if.err_cnt, exp_cnt(nerr)); end
      // Idle cycle in between confirms chk_err is a single-cycle pulse
      u_if.chk_valid = 1'b0;
      tick();
      checks++;
      if (u_if.chk_err !== 1'b0) begin failures++; $display("FAIL chk_idle[%0d] got=%b exp=0", i, u_if.chk_err); end
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    u_if.chk_valid = 1'b1;
    u_if.chk_frame = 9'h002;
    u_if.chk_odd   = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (u_if.err_cnt !== exp_cnt(k)) begin failures++; $display("FAIL sat_cnt[%0d] got=%h exp=%h", k, u_if.err_cnt, exp_cnt(k)); end
    end
    u_if.err_clr = 1'b1;
    tick();
    checks += 2;
    if (u_if.err_cnt !== exp_cnt(1)) begin failures++; $display("FAIL clr_with_err got=%h exp=%h", u_if.err_cnt, exp_cnt(1)); end
    if (u_if.chk_err !== 1'b1) begin failures++; $display("FAIL clr_chk_err got=%b exp=1", u_if.chk_err); end
    u_if.chk_valid = 1'b0;
    tick();
    checks++;
    if (u_if.err_cnt !== 4'h0) begin failures++; $display("FAIL clr_alone got=%h exp=0", u_if.err_cnt); end
    u_if.err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    u_if.out_ready  = 1'b0;
    u_if.in_valid   = 1'b1;
    u_if.parity_odd = 1'b0;
    u_if.chk_valid  = 1'b1;
    u_if.chk_frame  = 9'h002;
    u_if.chk_odd    = 1'b0;
    u_if.in_data    = 8'h55;
    tick();
    u_if.in_data = 8'h66;
    tick();
    checks += 3;
    if (u_if.in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", u_if.in_ready); end
    if (u_if.out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", u_if.out_valid); end
    if (u_if.err_cnt !== exp_cnt(2)) begin failures++; $display("FAIL mid_cnt got=%h exp=%h", u_if.err_cnt, exp_cnt(2)); end
    u_if.in_valid = 1'b0;
    reset         = 1'b1;
    tick();
    checks += 5;
    if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", u_if.out_valid); end
    if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", u_if.in_ready); end
    if (u_if.err_cnt !== 4'h0) begin failures++; $display("FAIL mid_rst_cnt got=%h exp=0", u_if.err_cnt); end
    if (u_if.chk_err !== 1'b0) begin failures++; $display("FAIL mid_rst_chk got=%b exp=0", u_if.chk_err); end
    if (u_if.out_frame !== 9'h000) begin failures++; $display("FAIL mid_rst_frame got=%h exp=000", u_if.out_frame); end
    reset          = 1'b0;
    u_if.chk_valid = 1'b0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d] valid=%b frame=%h exp_valid=0", i, u_if.out_valid, u_if.out_frame); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_frames();
    test_all_values();
    test_backpressure();
    test_checker();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
